// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit-side blocks.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request after rr_last, wrapping modulo N_REQ.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Offset 1 is the requester just after rr_last; offset N_REQ wraps back to rr_last.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((32'(rr_last) + i) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart transmitter between N_REQ requesters,
// with a stall timeout that reclaims the grant from a requester idling mid-packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ*BYTE_W-1:0] req_byte,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    timeout_pulse
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] STALL_MAX   = {CNT_W{1'b1}};

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_last_q, rr_last_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             tout_q, tout_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_idx;
  logic             cur_valid;
  logic             cur_last;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req       (req_valid),
    .rr_last   (rr_last_q),
    .grant     (pick_onehot),
    .grant_idx (pick_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_last_q <= ID_W'(N_REQ - 1);
      stall_q   <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      stall_q   <= stall_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    stall_d   = stall_q;
    tout_d    = 1'b0;
    tx_byte   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    cur_valid = req_valid[grant_q];
    cur_last  = req_last[grant_q];

    unique case (state_q)
      ARB_IDLE: begin
        stall_d = '0;
        if (|pick_onehot) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        busy               = 1'b1;
        tx_byte            = req_byte[BYTE_W*grant_q +: BYTE_W];
        tx_valid           = cur_valid;
        req_ready[grant_q] = tx_ready;
        // A valid byte waiting on a slow uart is not a stall, so the count clears on valid alone.
        if (cur_valid) begin
          stall_d = '0;
          if (tx_ready && cur_last) begin
            state_d   = ARB_IDLE;
            rr_last_d = grant_q;
          end
        end else if ((TIMEOUT != 0) && (stall_q == STALL_LIMIT)) begin
          state_d   = ARB_IDLE;
          rr_last_d = grant_q;
          tout_d    = 1'b1;
          stall_d   = '0;
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign grant_id      = grant_q;
  assign timeout_pulse = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, expected bytes are
// queued in predicted grant order and compared as they reach the uart interface.
module tb_uart_tx_arbiter;

  localparam int unsigned N         = 4;
  localparam int unsigned UART_BUSY = 100;  // 10 bits at 200 ns with a 20 ns clock

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*8-1:0] req_byte;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_valid;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_pulse;

  always #10 clock = ~clock;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (16),
    .ID_W    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_byte      (req_byte),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  logic [8:0]   rq [N][$];  // {last, byte} per requester
  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_pass = 0;
  int           tout_seen = 0;
  int           busy_cnt = 0;
  bit           slow_uart = 1'b0;
  bit           hold_ready = 1'b0;
  logic [N-1:0] rdy_seen = '0;

  // Scoreboard: every accepted byte must be the next expected one, from the expected requester.
  always @(negedge clock) begin
    if (timeout_pulse === 1'b1) tout_seen++;
    if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL xfer_unexpected: got id=%0d byte=%h, want no transfer", grant_id, tx_byte);
      end else begin
        mon_e = exp_q.pop_front();
        if (tx_byte !== mon_e.data || grant_id !== mon_e.id || req_ready !== (4'b0001 << mon_e.id))
          $display("FAIL xfer: got id=%0d byte=%h ready=%b, want id=%0d byte=%h ready=%b",
                   grant_id, tx_byte, req_ready, mon_e.id, mon_e.data, 4'b0001 << mon_e.id);
        else n_pass++;
      end
    end
  end

  task automatic send(input int k, input logic [7:0] b, input bit last);
    rq[k].push_back({last, b});
    exp_q.push_back({2'(k), b});
  endtask

  task automatic drive();
    logic [8:0] it;
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() != 0) begin
        it             = rq[k][0];
        req_valid[k]   = 1'b1;
        req_byte[8*k +: 8] = it[7:0];
        req_last[k]    = it[8];
      end else begin
        req_valid[k]   = 1'b0;
        req_byte[8*k +: 8] = 8'h00;
        req_last[k]    = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, then update requesters and uart model after posedge.
  task automatic cycle();
    logic [N-1:0] acc;
    logic [8:0]   dump;
    @(negedge clock);
    acc      = req_valid & req_ready & {N{tx_ready}};
    rdy_seen = rdy_seen | req_ready;
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++)
      if (acc[k] && rq[k].size() != 0) dump = rq[k].pop_front();
    if (|acc) busy_cnt = UART_BUSY;
    else if (busy_cnt > 0) busy_cnt--;
    tx_ready = !hold_ready && (!slow_uart || busy_cnt == 0);
    drive();
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++)
      if (rq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int bound, output int idle, output bit ok);
    idle = 0;
    ok   = 1'b0;
    for (int c = 0; c < bound; c++) begin
      cycle();
      if (all_empty()) begin
        ok = 1'b1;
        break;
      end
      if (busy !== 1'b1) idle++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_ready = 1'b1;
    drive();
    cycle();
    cycle();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    else n_pass++;
    n_checks++;
    if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", tx_byte); else n_pass++;
    n_checks++;
    if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
    n_checks++;
    if (timeout_pulse !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_pulse);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    int idle;
    bit ok;
    rdy_seen = '0;
    send(2, 8'h48, 1'b0);
    send(2, 8'h69, 1'b1);
    drive();
    cycle();
    n_checks++;
    if (grant_id !== 2'd2 || busy !== 1'b1)
      $display("FAIL single_grant: got id=%0d busy=%b want id=2 busy=1", grant_id, busy);
    else n_pass++;
    drain(20, idle, ok);
    n_checks++;
    if (!ok) $display("FAIL single_drain: got timeout want drained"); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++;
    if ((rdy_seen & 4'b1011) !== 4'b0000)
      $display("FAIL single_other_ready: got %b want 0000", rdy_seen & 4'b1011);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL single_left: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_contention();
    int idle;
    bit ok;
    pulse_reset();
    for (int k = 0; k < N; k++) begin
      if (k != 2) begin
        send(k, 8'h10 + 8'(k), 1'b0);
        send(k, 8'h20 + 8'(k), 1'b1);
      end
    end
    drive();
    drain(40, idle, ok);
    n_checks++;
    if (!ok) $display("FAIL rr_drain: got timeout want drained"); else n_pass++;
    n_checks++;
    if (idle !== 2) $display("FAIL rr_idle_gaps: got %0d want 2", idle); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rr_left: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_fairness();
    int idle;
    bit ok;
    // Grant order 0, 1, 0: req 0's second packet sits behind req 1.
    send(0, 8'h30, 1'b0);
    send(0, 8'h31, 1'b1);
    send(1, 8'h40, 1'b0);
    send(1, 8'h41, 1'b1);
    send(0, 8'h32, 1'b0);
    send(0, 8'h33, 1'b1);
    drive();
    drain(40, idle, ok);
    n_checks++;
    if (!ok || idle !== 2) $display("FAIL fair_drain: got ok=%b idle=%0d want ok=1 idle=2", ok, idle);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL fair_left: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int idle;
    bit ok;
    int t0;
    t0        = tout_seen;
    slow_uart = 1'b1;
    busy_cnt  = 0;
    for (int i = 0; i < 5; i++) send(1, 8'h55 + 8'(i), i == 4);
    drive();
    drain(800, idle, ok);
    slow_uart = 1'b0;
    busy_cnt  = 0;
    tx_ready  = 1'b1;
    n_checks++;
    if (!ok) $display("FAIL bp_drain: got timeout want drained"); else n_pass++;
    n_checks++;
    if (idle !== 0) $display("FAIL bp_busy_gap: got %0d idle cycles want 0", idle); else n_pass++;
    n_checks++;
    if (tout_seen !== t0) $display("FAIL bp_timeout: got %0d pulses want 0", tout_seen - t0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bp_left: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    int idle;
    bit ok;
    int n;
    bit seen;
    int t0;
    t0 = tout_seen;
    send(3, 8'hAA, 1'b0);
    send(0, 8'h60, 1'b1);
    drive();
    cycle();  // req 3 granted
    cycle();  // 0xAA accepted, req 3 goes quiet
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      n++;
      if (timeout_pulse === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || n !== 16) $display("FAIL tout_delay: got seen=%b after %0d want 16", seen, n);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL tout_busy: got %b want 0", busy); else n_pass++;
    cycle();
    n_checks++;
    if (timeout_pulse !== 1'b0) $display("FAIL tout_width: got %b want 0", timeout_pulse);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0)
      $display("FAIL tout_regrant: got id=%0d busy=%b want id=0 busy=1", grant_id, busy);
    else n_pass++;
    drain(20, idle, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0 || tout_seen - t0 !== 1)
      $display("FAIL tout_end: got ok=%b left=%0d pulses=%0d want 1/0/1", ok, exp_q.size(),
               tout_seen - t0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    int idle;
    bit ok;
    send(2, 8'h70, 1'b0);
    rq[2].push_back({1'b0, 8'h71});
    rq[2].push_back({1'b1, 8'h72});
    drive();
    cycle();
    cycle();  // 0x70 accepted
    hold_ready = 1'b1;
    tx_ready   = 1'b0;
    reset      = 1'b1;
    cycle();
    reset      = 1'b0;
    hold_ready = 1'b0;
    tx_ready   = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0)
      $display("FAIL midrst_state: got busy=%b valid=%b ready=%b id=%0d want 0/0/0000/0",
               busy, tx_valid, req_ready, grant_id);
    else n_pass++;
    send(0, 8'h80, 1'b1);
    exp_q.push_back({2'd2, 8'h71});
    exp_q.push_back({2'd2, 8'h72});
    drive();
    cycle();
    n_checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1)
      $display("FAIL midrst_first: got id=%0d busy=%b want id=0 busy=1", grant_id, busy);
    else n_pass++;
    drain(30, idle, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0)
      $display("FAIL midrst_end: got ok=%b left=%0d want 1/0", ok, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    test_reset();
    test_single_packet();
    test_contention();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
